// File: rtl/fold2_sched_ctrl.sv
// Sequencing controller for a 2-folded filter datapath.
// Produces the fold-phase select (switch) and datapath enable, accepts samples
// through a valid/ready handshake, swaps coefficients only on sample
// boundaries, and tracks in-flight samples with a token pipe so each accepted
// sample yields exactly one valid-qualified output. When input runs dry the
// datapath is fed zero samples until every outstanding result has come out.
module fold2_sched_ctrl #(
  parameter int N    = 16,  // sample / coefficient width
  parameter int FOLD = 2,   // clock cycles per sample period (>= 2)
  parameter int LAT  = 2    // datapath latency in sample periods (>= 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x_in,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [N-1:0] cfg_a,
  input  logic [N-1:0] cfg_b,
  input  logic         cfg_load,
  output logic [N-1:0] x_out,
  output logic [N-1:0] a_out,
  output logic [N-1:0] b_out,
  output logic         switch,
  output logic         dp_en,
  input  logic [N-1:0] y_in,
  output logic [N-1:0] y_out,
  output logic         y_valid,
  output logic         busy
);

  localparam int PW = (FOLD > 2) ? $clog2(FOLD) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(FOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [N-1:0]    x_q, x_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    sh_a_q, sh_a_d;
  logic [N-1:0]    sh_b_q, sh_b_d;
  logic            pend_q, pend_d;
  logic [N-1:0]    y_q, y_d;
  logic            yv_q, yv_d;
  logic [LAT-1:0]  tok_q, tok_d;

  logic boundary;
  logic accept;
  logic tok_pending;

  // A sample boundary is the last phase of a running period, or any idle cycle.
  assign boundary    = (state_q == S_IDLE) || (phase_q == PH_LAST);
  assign accept      = x_valid && x_ready;
  assign tok_pending = |tok_q;

  assign x_out   = x_q;
  assign a_out   = a_q;
  assign b_out   = b_q;
  assign y_out   = y_q;
  assign y_valid = yv_q;

  // FSM state register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: decisions are taken only on sample boundaries.
  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (boundary) begin
      if (accept)           state_d = S_RUN;
      else if (tok_pending) state_d = S_FLUSH;
      else                  state_d = S_IDLE;
    end
  end

  // FSM outputs: phase select, datapath enable and handshake ready.
  always_comb begin
    dp_en   = (state_q != S_IDLE);
    busy    = (state_q != S_IDLE);
    switch  = (phase_q == '0);
    x_ready = (state_q == S_IDLE) ? (phase_q == '0) : (phase_q == PH_LAST);
  end

  // Next values for phase, sample, coefficients, token pipe and output stage.
  always_comb begin
    phase_d = '0;
    if ((state_q != S_IDLE) && (phase_q != PH_LAST)) phase_d = phase_q + PW'(1);

    x_d    = x_q;
    a_d    = a_q;
    b_d    = b_q;
    sh_a_d = sh_a_q;
    sh_b_d = sh_b_q;
    pend_d = pend_q;
    tok_d  = tok_q;
    y_d    = y_q;
    yv_d   = 1'b0;

    if (cfg_load) begin
      sh_a_d = cfg_a;
      sh_b_d = cfg_b;
    end

    if (boundary) begin
      // Shift the token pipe; the tail token marks the result arriving now.
      tok_d[0] = accept;
      for (int i = 1; i < LAT; i++) tok_d[i] = tok_q[i-1];
      if (tok_q[LAT-1]) begin
        y_d  = y_in;
        yv_d = 1'b1;
      end

      // Fresh sample, zero bubble while draining, else hold when going idle.
      if (accept)           x_d = x_in;
      else if (tok_pending) x_d = '0;

      // A load landing on the boundary itself takes effect straight away.
      if (cfg_load) begin
        a_d = cfg_a;
        b_d = cfg_b;
      end else if (pend_q) begin
        a_d = sh_a_q;
        b_d = sh_b_q;
      end
      pend_d = 1'b0;
    end else if (cfg_load) begin
      pend_d = 1'b1;
    end
  end

  // Datapath-facing registers; reset drops all in-flight tokens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      x_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      pend_q  <= 1'b0;
      tok_q   <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      pend_q  <= pend_d;
      tok_q   <= tok_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

endmodule

// File: tb/tb_fold2_sched_ctrl.sv
// Self-checking bench for fold2_sched_ctrl. A sample-level reference model
// (position in the sample period plus a queue of per-sample countdowns to the
// result) predicts every output each cycle; directed sequences add literal
// expectations for reset, coefficient timing, gaps, async reset and latency.
module tb_fold2_sched_ctrl;

  localparam int N    = 16;
  localparam int FOLD = 2;
  localparam int LAT  = 2;

  logic         clk      = 1'b0;
  logic         rst      = 1'b0;
  logic [N-1:0] x_in     = '0;
  logic         x_valid  = 1'b0;
  logic [N-1:0] cfg_a    = '0;
  logic [N-1:0] cfg_b    = '0;
  logic         cfg_load = 1'b0;
  logic [N-1:0] y_in     = '0;
  logic         x_ready, switch, dp_en, y_valid, busy;
  logic [N-1:0] x_out, a_out, b_out, y_out;

  fold2_sched_ctrl #(.N(N), .FOLD(FOLD), .LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .x_in     (x_in),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .cfg_a    (cfg_a),
    .cfg_b    (cfg_b),
    .cfg_load (cfg_load),
    .x_out    (x_out),
    .a_out    (a_out),
    .b_out    (b_out),
    .switch   (switch),
    .dp_en    (dp_en),
    .y_in     (y_in),
    .y_out    (y_out),
    .y_valid  (y_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_err  = 0;
  int cyc    = 0;
  int yv_cnt = 0;
  int yc[$];
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] s16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return {16'b0, t};
  endfunction

  // ---------------- reference model ----------------
  bit           m_active = 1'b0;
  int           m_pos    = 0;
  logic [N-1:0] m_x = '0, m_a = '0, m_b = '0, m_sha = '0, m_shb = '0, m_y = '0;
  bit           m_pend = 1'b0, m_yv = 1'b0;
  int           m_fly[$];

  initial begin
    bit bnd, acc, pending;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 1'b0; m_pos = 0; m_x = '0; m_a = '0; m_b = '0;
        m_sha = '0; m_shb = '0; m_y = '0; m_pend = 1'b0; m_yv = 1'b0;
        m_fly.delete();
      end else begin
        bnd = !m_active || (m_pos == FOLD - 1);
        acc = x_valid && bnd;
        foreach (m_fly[i]) m_fly[i]--;
        pending = (m_fly.size() > 0);
        m_yv = 1'b0;
        if (pending && m_fly[0] == 0) begin
          m_yv = 1'b1;
          m_y  = y_in;
          void'(m_fly.pop_front());
        end
        if (bnd) begin
          if (acc) begin
            m_fly.push_back(LAT * FOLD);
            m_x = x_in;
            m_active = 1'b1;
          end else if (pending) begin
            m_x = '0;
            m_active = 1'b1;
          end else begin
            m_active = 1'b0;
          end
          m_pos = 0;
          if (cfg_load) begin
            m_a = cfg_a; m_b = cfg_b; m_sha = cfg_a; m_shb = cfg_b;
          end else if (m_pend) begin
            m_a = m_sha; m_b = m_shb;
          end
          m_pend = 1'b0;
        end else begin
          m_pos++;
          if (cfg_load) begin
            m_sha = cfg_a; m_shb = cfg_b; m_pend = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("switch",  switch,  m_pos == 0);
      check("dp_en",   dp_en,   m_active);
      check("busy",    busy,    m_active);
      check("x_ready", x_ready, !m_active || (m_pos == FOLD - 1));
      check("x_out",   x_out,   m_x);
      check("a_out",   a_out,   m_a);
      check("b_out",   b_out,   m_b);
      check("y_valid", y_valid, m_yv);
      if (m_yv) check("y_out", y_out, m_y);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (y_valid) begin
      yv_cnt++;
      yc.push_back(cyc);
    end
  end

  // Stand-in datapath result: a distinct value every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1 y_in = y_in + 16'h0111;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, output int acc_at);
    int waited;
    x_in    = 16'(v);
    x_valid = 1'b1;
    waited  = 0;
    acc_at  = -1;
    while (acc_at < 0 && waited < 8) begin
      if (x_ready) begin
        tick();
        acc_at = cyc;
      end else begin
        tick();
        waited++;
      end
    end
    x_valid = 1'b0;
    if (acc_at < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: sample %0d not accepted within 8 cycles", v);
    end
  endtask

  initial begin
    int vals[6];
    int acc0, acc_last, a_tmp, y0, bcount, lat;
    vals = '{-3, 5, 2, -2, 4, 1};

    // Reset for three cycles, released mid-cycle.
    #2 rst = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    check("rst_switch",  switch,  1);
    check("rst_dp_en",   dp_en,   0);
    check("rst_x_ready", x_ready, 1);
    check("rst_y_valid", y_valid, 0);
    check("rst_a_out",   a_out,   0);
    check("rst_b_out",   b_out,   0);
    check("rst_busy",    busy,    0);
    tick();

    // Coefficient load from IDLE applies on the next cycle.
    cfg_a = 16'd2; cfg_b = 16'd3; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("idle_load_a", a_out, 2);
    check("idle_load_b", b_out, 3);

    // Continuous stream of six samples.
    y0 = yv_cnt;
    acc0 = -1; acc_last = -1;
    foreach (vals[i]) begin
      send(vals[i], a_tmp);
      if (i == 0) begin
        acc0 = a_tmp;
        check("first_x_out",  x_out,  s16(-3));
        check("first_switch", switch, 1);
      end
      acc_last = a_tmp;
    end
    check("accept_spacing", acc_last - acc0, 5 * FOLD);
    bcount = 0;
    repeat (12) begin
      if (busy) bcount++;
      tick();
    end
    check("busy_tail_cycles", bcount, 6);
    check("stream_y_count",   yv_cnt - y0, 6);
    lat = (yc.size() > y0) ? (yc[y0] - acc0) : -1;
    check("first_y_latency", lat, 4);

    // Mid-period coefficient change waits for the next period.
    send(6, a_tmp);
    cfg_a = 16'd3; cfg_b = 16'd5; cfg_load = 1'b1;
    check("midload_p0_a", a_out, 2);
    tick();
    cfg_load = 1'b0;
    check("midload_p1_a", a_out, 2);
    check("midload_p1_b", b_out, 3);
    tick();
    check("midload_next_a", a_out, 3);
    check("midload_next_b", b_out, 5);
    repeat (8) tick();

    // One-boundary gap: a single zero bubble period, no extra output.
    y0 = yv_cnt;
    send(7, a_tmp);
    send(8, a_tmp);
    tick();
    tick();
    check("gap_x_zero", x_out, 0);
    check("gap_dp_en",  dp_en, 1);
    send(9, a_tmp);
    check("resume_x", x_out, 9);
    send(10, a_tmp);
    repeat (10) tick();
    check("gap_y_count", yv_cnt - y0, 4);
    check("gap_idle",    busy, 0);

    // Async reset with two tokens in flight.
    send(11, a_tmp);
    send(12, a_tmp);
    #2 rst = 1'b1;
    #1;
    check("arst_y_valid", y_valid, 0);
    check("arst_dp_en",   dp_en,   0);
    check("arst_busy",    busy,    0);
    check("arst_x_out",   x_out,   0);
    check("arst_a_out",   a_out,   0);
    check("arst_switch",  switch,  1);
    @(posedge clk);
    #3 rst = 1'b0;
    y0 = yv_cnt;
    repeat (10) tick();
    check("arst_no_y", yv_cnt - y0, 0);
    send(13, a_tmp);
    repeat (8) tick();
    check("post_rst_y_count", yv_cnt - y0, 1);
    lat = (yc.size() > y0) ? (yc[y0] - a_tmp) : -1;
    check("post_rst_latency", lat, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
